// File: rtl/bht_predictor.sv
// Branch history table: ENTRIES saturating counters indexed by PC, optionally gshare-hashed
// with a non-speculative global history. Table is swept to INIT_CTR after every reset.
module bht_predictor #(
    parameter int unsigned ENTRIES  = 64,
    parameter int unsigned CTR_BITS = 2,
    parameter int unsigned PC_WIDTH = 32,
    parameter int unsigned GHR_BITS = 6,
    parameter int unsigned INIT_CTR = 1,
    localparam int unsigned IDX_W   = $clog2(ENTRIES),
    localparam int unsigned GHR_W   = (GHR_BITS > 0) ? GHR_BITS : 1
) (
    input  logic                clock,
    input  logic                reset,
    output logic                ready,
    input  logic                lookup_valid,
    input  logic [PC_WIDTH-1:0] lookup_pc,
    output logic                predict_valid,
    output logic                predict_taken,
    output logic [IDX_W-1:0]    predict_idx,
    input  logic                update_valid,
    input  logic [IDX_W-1:0]    update_idx,
    input  logic                update_taken,
    output logic [GHR_W-1:0]    ghr
);

    localparam logic [0:0]          ST_INIT  = 1'b0;
    localparam logic [0:0]          ST_RUN   = 1'b1;
    localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0] CTR_ONE  = CTR_BITS'(1);
    localparam logic [CTR_BITS-1:0] CTR_RST  = CTR_BITS'(INIT_CTR);
    localparam logic [IDX_W-1:0]    IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(ENTRIES - 1);

    function automatic logic [CTR_BITS-1:0] ctr_next(input logic [CTR_BITS-1:0] ctr,
                                                     input logic                taken);
        if (taken) begin
            return (ctr == CTR_MAX) ? ctr : ctr + CTR_ONE;
        end
        return (ctr == '0) ? ctr : ctr - CTR_ONE;
    endfunction

    logic [0:0]          state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [GHR_W-1:0]    ghr_q, ghr_d;
    logic [CTR_BITS-1:0] ctr_q [ENTRIES];
    logic [CTR_BITS-1:0] ctr_d [ENTRIES];
    logic                predict_valid_q, predict_valid_d;
    logic                predict_taken_q, predict_taken_d;
    logic [IDX_W-1:0]    predict_idx_q, predict_idx_d;

    logic                run;
    logic                upd_en;
    logic                lkp_en;
    logic [IDX_W-1:0]    ghr_ext;
    logic [IDX_W-1:0]    lkp_idx;
    logic [CTR_BITS-1:0] upd_ctr;
    logic [CTR_BITS-1:0] lkp_ctr;

    assign run    = (state_q == ST_RUN);
    assign upd_en = run & update_valid;
    assign lkp_en = run & lookup_valid;
    assign ready  = run;
    assign ghr    = ghr_q;

    assign predict_valid = predict_valid_q;
    assign predict_taken = predict_taken_q;
    assign predict_idx   = predict_idx_q;

    // Word-aligned PC: low two bits and bits above the index never reach the table.
    logic unused_pc;
    if (PC_WIDTH > IDX_W + 2) begin : g_pc_hi
        assign unused_pc = ^{lookup_pc[PC_WIDTH-1:IDX_W+2], lookup_pc[1:0]};
    end else begin : g_pc_exact
        assign unused_pc = ^lookup_pc[1:0];
    end

    if (GHR_BITS == 0) begin : g_bimodal
        assign ghr_ext = '0;
        assign ghr_d   = '0;
    end else if (GHR_BITS == 1) begin : g_ghr1
        assign ghr_ext = IDX_W'(ghr_q);
        assign ghr_d   = upd_en ? update_taken : ghr_q;
    end else begin : g_ghrn
        assign ghr_ext = IDX_W'(ghr_q);
        assign ghr_d   = upd_en ? {ghr_q[GHR_BITS-2:0], update_taken} : ghr_q;
    end

    // Lookup hashes with the pre-update history.
    assign lkp_idx = lookup_pc[IDX_W+1:2] ^ ghr_ext;
    assign upd_ctr = ctr_next(ctr_q[update_idx], update_taken);

    always_comb begin
        lkp_ctr = ctr_q[lkp_idx];
        // Same-cycle update to the looked-up entry is forwarded.
        if (upd_en && (update_idx == lkp_idx)) begin
            lkp_ctr = upd_ctr;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (state_q == ST_INIT) begin
            ptr_d = ptr_q + IDX_ONE;
            if (ptr_q == LAST_IDX) begin
                state_d = ST_RUN;
                ptr_d   = '0;
            end
        end
    end

    always_comb begin
        ctr_d = ctr_q;
        if (state_q == ST_INIT) begin
            ctr_d[ptr_q] = CTR_RST;
        end else if (upd_en) begin
            ctr_d[update_idx] = upd_ctr;
        end
    end

    always_comb begin
        predict_valid_d = lkp_en;
        predict_taken_d = predict_taken_q;
        predict_idx_d   = predict_idx_q;
        if (lkp_en) begin
            predict_taken_d = lkp_ctr[CTR_BITS-1];
            predict_idx_d   = lkp_idx;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= ST_INIT;
            ptr_q           <= '0;
            ghr_q           <= '0;
            predict_valid_q <= 1'b0;
            predict_taken_q <= 1'b0;
            predict_idx_q   <= '0;
        end else begin
            state_q         <= state_d;
            ptr_q           <= ptr_d;
            ghr_q           <= ghr_d;
            predict_valid_q <= predict_valid_d;
            predict_taken_q <= predict_taken_d;
            predict_idx_q   <= predict_idx_d;
        end
    end

    // No reset on the table itself; the INIT sweep rewrites every entry.
    always_ff @(posedge clock) begin
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            ctr_q[i] <= ctr_d[i];
        end
    end

endmodule

// File: tb/tb_bht_predictor.sv
// Bench for bht_predictor: a bimodal and a gshare instance share stimulus and are each
// compared every cycle against an array-based model, plus directed scenario checks.
module tb_bht_predictor;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        lookup_valid = 1'b0;
    logic [31:0] lookup_pc = '0;
    logic        update_valid = 1'b0;
    logic [5:0]  update_idx = '0;
    logic        update_taken = 1'b0;

    logic       bi_ready, bi_pv, bi_pt;
    logic [5:0] bi_pidx;
    logic [0:0] bi_ghr;
    logic       gs_ready, gs_pv, gs_pt;
    logic [5:0] gs_pidx;
    logic [5:0] gs_ghr;

    always #5 clock = ~clock;

    bht_predictor #(.ENTRIES(64), .CTR_BITS(2), .PC_WIDTH(32), .GHR_BITS(0), .INIT_CTR(1)) u_bi (
        .clock(clock), .reset(reset), .ready(bi_ready),
        .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
        .predict_valid(bi_pv), .predict_taken(bi_pt), .predict_idx(bi_pidx),
        .update_valid(update_valid), .update_idx(update_idx), .update_taken(update_taken),
        .ghr(bi_ghr)
    );

    bht_predictor #(.ENTRIES(64), .CTR_BITS(2), .PC_WIDTH(32), .GHR_BITS(6), .INIT_CTR(1)) u_gs (
        .clock(clock), .reset(reset), .ready(gs_ready),
        .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
        .predict_valid(gs_pv), .predict_taken(gs_pt), .predict_idx(gs_pidx),
        .update_valid(update_valid), .update_idx(update_idx), .update_taken(update_taken),
        .ghr(gs_ghr)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int m_bi [64];
    int m_gs [64];
    int m_ghr = 0;
    int init_left = 64;
    int e_bi_pv = 0, e_bi_pt = 0, e_bi_pidx = 0;
    int e_gs_pv = 0, e_gs_pt = 0, e_gs_pidx = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int sat(input int c, input logic t);
        if (t) return (c < 3) ? c + 1 : 3;
        return (c > 0) ? c - 1 : 0;
    endfunction

    task automatic step(input logic rst, input logic lv, input logic [31:0] pc,
                        input logic uv, input logic [5:0] uidx, input logic ut);
        int bidx, gidx;
        reset        = rst;
        lookup_valid = lv;
        lookup_pc    = pc;
        update_valid = uv;
        update_idx   = uidx;
        update_taken = ut;
        @(posedge clock);
        if (rst) begin
            init_left = 64;
            for (int i = 0; i < 64; i++) begin
                m_bi[i] = 1;
                m_gs[i] = 1;
            end
            m_ghr = 0;
            e_bi_pv = 0; e_bi_pt = 0; e_bi_pidx = 0;
            e_gs_pv = 0; e_gs_pt = 0; e_gs_pidx = 0;
        end else if (init_left > 0) begin
            init_left--;
            e_bi_pv = 0;
            e_gs_pv = 0;
        end else begin
            bidx = int'((pc >> 2) & 32'h3f);
            gidx = bidx ^ m_ghr;
            if (uv) begin
                m_bi[uidx] = sat(m_bi[uidx], ut);
                m_gs[uidx] = sat(m_gs[uidx], ut);
                m_ghr = ((m_ghr << 1) | int'(ut)) & 63;
            end
            e_bi_pv = int'(lv);
            e_gs_pv = int'(lv);
            if (lv) begin
                e_bi_pidx = bidx;
                e_bi_pt   = (m_bi[bidx] >= 2) ? 1 : 0;
                e_gs_pidx = gidx;
                e_gs_pt   = (m_gs[gidx] >= 2) ? 1 : 0;
            end
        end
        #1;
        check("bi_ready", 32'(bi_ready), (init_left == 0) ? 1 : 0);
        check("bi_pvalid", 32'(bi_pv), e_bi_pv);
        check("bi_ptaken", 32'(bi_pt), e_bi_pt);
        check("bi_pidx", 32'(bi_pidx), e_bi_pidx);
        check("bi_ghr", 32'(bi_ghr), 0);
        check("gs_ready", 32'(gs_ready), (init_left == 0) ? 1 : 0);
        check("gs_pvalid", 32'(gs_pv), e_gs_pv);
        check("gs_ptaken", 32'(gs_pt), e_gs_pt);
        check("gs_pidx", 32'(gs_pidx), e_gs_pidx);
        check("gs_ghr", 32'(gs_ghr), m_ghr);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'h0, 1'b0, 6'd0, 1'b0);
    endtask

    task automatic upd(input logic [5:0] idx, input logic t);
        step(1'b0, 1'b0, 32'h0, 1'b1, idx, t);
    endtask

    task automatic look(input logic [31:0] pc);
        step(1'b0, 1'b1, pc, 1'b0, 6'd0, 1'b0);
    endtask

    // Counts cycles with ready low; lookups and idx5 updates offered meanwhile must be ignored.
    task automatic wait_ready(output int cnt);
        cnt = 0;
        while (bi_ready !== 1'b1 && cnt < 100) begin
            cnt++;
            step(1'b0, 1'b1, 32'h40, 1'b1, 6'd5, 1'b1);
        end
    endtask

    initial begin
        int cnt;
        logic [5:0] ridx;

        // T1: reset, init sweep length, first lookup
        step(1'b1, 1'b0, 32'h0, 1'b0, 6'd0, 1'b0);
        check("t1_reset_ready", 32'(bi_ready), 0);
        check("t1_reset_ghr", 32'(gs_ghr), 0);
        wait_ready(cnt);
        check("t1_init_cycles", cnt, 64);
        look(32'h40);
        check("t1_pvalid", 32'(bi_pv), 1);
        check("t1_ptaken", 32'(bi_pt), 0);
        check("t1_pidx", 32'(bi_pidx), 16);
        idle();
        check("t1_pvalid_drop", 32'(bi_pv), 0);
        check("t1_pidx_hold", 32'(bi_pidx), 16);

        // T2: saturating up, then back down
        upd(6'd5, 1'b1);
        upd(6'd5, 1'b1);
        look(32'h14);
        check("t2_taken_sat", 32'(bi_pt), 1);
        upd(6'd5, 1'b1);
        upd(6'd5, 1'b0);
        look(32'h14);
        check("t2_taken_2", 32'(bi_pt), 1);
        upd(6'd5, 1'b0);
        look(32'h14);
        check("t2_taken_1", 32'(bi_pt), 0);

        // T3: saturate at zero
        upd(6'd9, 1'b0);
        upd(6'd9, 1'b0);
        upd(6'd9, 1'b0);
        upd(6'd9, 1'b1);
        look(32'h24);
        check("t3_floor_1", 32'(bi_pt), 0);
        upd(6'd9, 1'b1);
        look(32'h24);
        check("t3_floor_2", 32'(bi_pt), 1);

        // T4: forwarding of a same-cycle update
        step(1'b0, 1'b1, 32'h1c, 1'b1, 6'd7, 1'b1);
        check("t4_forward", 32'(bi_pt), 1);
        check("t4_idx", 32'(bi_pidx), 7);

        // T6: reset mid-run after training idx5, updates during INIT dropped
        upd(6'd5, 1'b1);
        upd(6'd5, 1'b1);
        look(32'h14);
        check("t6_trained", 32'(bi_pt), 1);
        step(1'b1, 1'b0, 32'h0, 1'b0, 6'd0, 1'b0);
        wait_ready(cnt);
        check("t6_init_cycles", cnt, 64);
        check("t6_ghr_clear", 32'(gs_ghr), 0);
        look(32'h14);
        check("t6_untrained", 32'(bi_pt), 0);

        // T5: gshare history and old-ghr hashing
        upd(6'd40, 1'b1);
        upd(6'd40, 1'b1);
        step(1'b0, 1'b1, 32'h0, 1'b1, 6'd40, 1'b1);
        check("t5_old_ghr_idx", 32'(gs_pidx), 3);
        check("t5_ghr", 32'(gs_ghr), 7);
        look(32'h0);
        check("t5_gs_idx", 32'(gs_pidx), 7);
        check("t5_bi_idx", 32'(bi_pidx), 0);

        // Random traffic, biased toward a few hot entries to hit saturation
        for (int i = 0; i < 1500; i++) begin
            ridx = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 7)) : 6'($urandom);
            step(($urandom_range(0, 299) == 0), 1'($urandom), $urandom,
                 1'($urandom), ridx, ($urandom_range(0, 3) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
